// File: rtl/cluster_priority_iter.sv
// cluster_priority_iter: iterative lowest-index cluster extractor.
// A frame of per-pad valid flags and counts is captured on start_i. One
// cluster is then emitted per search step in ascending pad order. Each
// found pad is masked off before the next step. The frame ends after
// MXCLUSTERS clusters or when no flagged pad remains, and reports the
// cluster count and an overflow flag on done_o.
// Optional build macro PRIORITY_TREE_PIPE_EN adds a register stage at the
// tree midpoint. Each search step then takes two cycles.
module cluster_priority_iter #(
  parameter int MXKEYS     = 384,
  parameter int MXKEYBITS  = 9,
  parameter int MXCNTB     = 3,
  parameter int MXCLUSTERS = 8,
  parameter int MXCLSTB    = 4
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       start_i,
  input  logic [2:0]                 pass_i,
  input  logic [MXKEYS-1:0]          vpfs_i,
  input  logic [MXKEYS*MXCNTB-1:0]   cnts_i,
  output logic                       busy_o,
  output logic                       vpf_o,
  output logic [MXKEYBITS-1:0]       adr_o,
  output logic [MXCNTB-1:0]          cnt_o,
  output logic [MXCLSTB-1:0]         idx_o,
  output logic [2:0]                 pass_o,
  output logic                       done_o,
  output logic [MXCLSTB-1:0]         nclusters_o,
  output logic                       overflow_o
);

  localparam int LVL       = $clog2(MXKEYS);
  localparam int NPAD      = 1 << LVL;
  localparam int MID       = (LVL + 1) / 2;
  localparam int REG_DEPTH = LVL - MID;
  localparam logic [MXCLSTB-1:0] KMAX = MXCLSTB'(MXCLUSTERS);

  typedef enum logic [1:0] {IDLE, SEARCH, FINISH} state_t;

  state_t                     state, state_nxt;
  logic [MXKEYS-1:0]          mask;
  logic [MXKEYS*MXCNTB-1:0]   cnts_q;
  logic [MXCLSTB-1:0]         k;
  logic                       step;
  logic                       load, emit, fin;
  logic                       found;
  logic [MXKEYBITS-1:0]       pad;
  logic [NPAD-1:0]            mask_pad;

  // Heap-ordered tree: node i has children 2i (lower pads) and 2i+1.
  logic                       hv [1:2*NPAD-1];
  logic [MXKEYBITS-1:0]       ha [1:2*NPAD-1];

`ifdef PRIORITY_TREE_PIPE_EN
  localparam bit PIPE = 1'b1;
  logic phase;

  // Alternate between a tree-fill cycle and a decision cycle while searching.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)                 phase <= 1'b0;
    else if (state == SEARCH)  phase <= ~phase;
    else                       phase <= 1'b0;
  end
  assign step = phase;
`else
  localparam bit PIPE = 1'b0;
  assign step = 1'b1;
`endif

  // Padded leaves are tied to zero, so they never win.
  assign mask_pad = NPAD'(mask);

  for (genvar p = 0; p < NPAD; p++) begin : g_leaf
    assign hv[NPAD+p] = mask_pad[p];
    assign ha[NPAD+p] = MXKEYBITS'(p);
  end

  for (genvar i = 1; i < NPAD; i++) begin : g_node
    localparam int DEPTH = $clog2(i + 1) - 1;
    logic                 vc;
    logic [MXKEYBITS-1:0] ac;

    // The lower-index child wins whenever it holds a valid pad.
    assign vc = hv[2*i] | hv[2*i+1];
    assign ac = hv[2*i] ? ha[2*i] : ha[2*i+1];

    if (PIPE && (DEPTH == REG_DEPTH)) begin : g_reg
      logic                 vr;
      logic [MXKEYBITS-1:0] ar;

      // Midpoint pipeline register of the tree.
      always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
          vr <= 1'b0;
          ar <= '0;
        end else begin
          vr <= vc;
          ar <= ac;
        end
      end
      assign hv[i] = vr;
      assign ha[i] = ar;
    end else begin : g_comb
      assign hv[i] = vc;
      assign ha[i] = ac;
    end
  end

  assign found  = hv[1];
  assign pad    = ha[1];
  assign busy_o = (state != IDLE);

  // Frame state register.
  always_ff @(posedge clock or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state and step decisions.
  always_comb begin
    // NOTE: every output of this block gets a default first; a path that
    // left one unassigned would infer a latch.
    state_nxt = state;
    load      = 1'b0;
    emit      = 1'b0;
    fin       = 1'b0;
    case (state)
      IDLE: begin
        if (start_i) begin
          load      = 1'b1;
          state_nxt = SEARCH;
        end
      end
      SEARCH: begin
        if (step) begin
          if (found && (k < KMAX)) emit      = 1'b1;
          else                     state_nxt = FINISH;
        end
      end
      FINISH: begin
        fin       = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Count capture.
  always_ff @(posedge clock) begin
    // NOTE: the count store is deliberately not reset. A count is read only
    // for a pad whose mask bit is set, and the mask itself is reset.
    if (load) cnts_q <= cnts_i;
  end

  // Mask, cluster counter and registered outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      mask        <= '0;
      k           <= '0;
      vpf_o       <= 1'b0;
      adr_o       <= '1;
      cnt_o       <= '0;
      idx_o       <= '0;
      pass_o      <= '0;
      done_o      <= 1'b0;
      nclusters_o <= '0;
      overflow_o  <= 1'b0;
    end else begin
      vpf_o  <= emit;
      adr_o  <= emit ? pad : '1;
      cnt_o  <= emit ? cnts_q[pad*MXCNTB +: MXCNTB] : '0;
      done_o <= fin;
      if (load) begin
        mask   <= vpfs_i;
        pass_o <= pass_i;
        k      <= '0;
      end
      if (emit) begin
        mask[pad] <= 1'b0;
        k         <= k + 1'b1;
        idx_o     <= k;
      end
      if (fin) begin
        nclusters_o <= k;
        overflow_o  <= |mask;
      end
    end
  end

endmodule

// File: tb/tb_cluster_priority_iter.sv
// Self-checking bench for cluster_priority_iter: a vector table applied by
// run_frame, plus hand-written abort and small-configuration sequences.
module tb_cluster_priority_iter;

`ifdef PRIORITY_TREE_PIPE_EN
  localparam bit PIPE = 1'b1;
`else
  localparam bit PIPE = 1'b0;
`endif

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          start_i = 1'b0;
  logic [2:0]    pass_i = '0;
  logic [383:0]  vpfs_i = '0;
  logic [1151:0] cnts_i = '0;
  logic          busy_o, vpf_o, done_o, overflow_o;
  logic [8:0]    adr_o;
  logic [2:0]    cnt_o, pass_o;
  logic [3:0]    idx_o, nclusters_o;

  logic          start2 = 1'b0;
  logic [2:0]    pass2 = '0;
  logic [23:0]   vpfs2 = '0;
  logic [71:0]   cnts2 = '0;
  logic          busy2, vpf2, done2, ovf2;
  logic [4:0]    adr2;
  logic [2:0]    cnt2, passo2;
  logic [3:0]    idx2, ncl2;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clock = ~clock;

  cluster_priority_iter dut (
    .clock(clock), .reset(reset), .start_i(start_i), .pass_i(pass_i),
    .vpfs_i(vpfs_i), .cnts_i(cnts_i), .busy_o(busy_o), .vpf_o(vpf_o),
    .adr_o(adr_o), .cnt_o(cnt_o), .idx_o(idx_o), .pass_o(pass_o),
    .done_o(done_o), .nclusters_o(nclusters_o), .overflow_o(overflow_o)
  );

  cluster_priority_iter #(.MXKEYS(24), .MXKEYBITS(5)) dut24 (
    .clock(clock), .reset(reset), .start_i(start2), .pass_i(pass2),
    .vpfs_i(vpfs2), .cnts_i(cnts2), .busy_o(busy2), .vpf_o(vpf2),
    .adr_o(adr2), .cnt_o(cnt2), .idx_o(idx2), .pass_o(passo2),
    .done_o(done2), .nclusters_o(ncl2), .overflow_o(ovf2)
  );

  typedef struct {
    bit         all_on;
    int         np;
    int         pad [9];
    int         cv [9];
    int         n;
    bit         ovf;
    int         eadr [8];
    int         ecnt [8];
    logic [2:0] pass;
    int         inj;
  } vec_t;

  vec_t tbl [7];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Edge after which cluster j is expected, or -1 when edge e carries none.
  function automatic int emit_j(input int e, input int n);
    int j;
    if (PIPE) j = ((e % 2) == 0) ? (e - 2) / 2 : -1;
    else      j = e - 1;
    return (j >= 0 && j < n) ? j : -1;
  endfunction

  function automatic int done_edge(input int n);
    return PIPE ? 2 * n + 3 : n + 2;
  endfunction

  task automatic check_idle(input string tag);
    check({tag, "_busy"}, 64'(busy_o), 64'(0));
    check({tag, "_vpf"},  64'(vpf_o), 64'(0));
    check({tag, "_adr"},  64'(adr_o), 64'h1FF);
    check({tag, "_cnt"},  64'(cnt_o), 64'(0));
    check({tag, "_idx"},  64'(idx_o), 64'(0));
    check({tag, "_pass"}, 64'(pass_o), 64'(0));
    check({tag, "_done"}, 64'(done_o), 64'(0));
    check({tag, "_ncl"},  64'(nclusters_o), 64'(0));
    check({tag, "_ovf"},  64'(overflow_o), 64'(0));
  endtask

  task automatic run_frame(input int t);
    int de, j;
    vpfs_i = tbl[t].all_on ? '1 : '0;
    for (int p = 0; p < 384; p++) cnts_i[p*3 +: 3] = 3'(p % 8);
    for (int i = 0; i < tbl[t].np; i++) begin
      vpfs_i[tbl[t].pad[i]] = 1'b1;
      cnts_i[tbl[t].pad[i]*3 +: 3] = 3'(tbl[t].cv[i]);
    end
    pass_i  = tbl[t].pass;
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    vpfs_i  = '0;
    cnts_i  = '0;
    pass_i  = '0;
    de = done_edge(tbl[t].n);
    for (int e = 1; e <= de; e++) begin
      tick();
      if (e == tbl[t].inj) begin
        start_i = 1'b1;
        vpfs_i  = '1;
        cnts_i  = '1;
        pass_i  = ~tbl[t].pass;
      end else begin
        start_i = 1'b0;
      end
      j = emit_j(e, tbl[t].n);
      check($sformatf("v%0d_e%0d_vpf", t, e), 64'(vpf_o), 64'(j >= 0));
      if (j >= 0) begin
        check($sformatf("v%0d_e%0d_adr", t, e), 64'(adr_o), 64'(tbl[t].eadr[j]));
        check($sformatf("v%0d_e%0d_cnt", t, e), 64'(cnt_o), 64'(tbl[t].ecnt[j]));
        check($sformatf("v%0d_e%0d_idx", t, e), 64'(idx_o), 64'(j));
      end else begin
        check($sformatf("v%0d_e%0d_adr_idle", t, e), 64'(adr_o), 64'h1FF);
      end
      check($sformatf("v%0d_e%0d_done", t, e), 64'(done_o), 64'(e == de));
      check($sformatf("v%0d_e%0d_busy", t, e), 64'(busy_o), 64'(e < de));
      check($sformatf("v%0d_e%0d_pass", t, e), 64'(pass_o), 64'(tbl[t].pass));
    end
    start_i = 1'b0;
    check($sformatf("v%0d_ncl", t), 64'(nclusters_o), 64'(tbl[t].n));
    check($sformatf("v%0d_ovf", t), 64'(overflow_o), 64'(tbl[t].ovf));
    tick();
    check($sformatf("v%0d_done_pulse", t), 64'(done_o), 64'(0));
    check($sformatf("v%0d_ncl_hold", t), 64'(nclusters_o), 64'(tbl[t].n));
    tick();
  endtask

  initial begin
    int j, de;
    bit saw;

    tbl[0] = '{all_on: 1'b0, np: 0, pad: '{0,0,0,0,0,0,0,0,0}, cv: '{0,0,0,0,0,0,0,0,0},
               n: 0, ovf: 1'b0, eadr: '{0,0,0,0,0,0,0,0}, ecnt: '{0,0,0,0,0,0,0,0},
               pass: 3'd0, inj: -1};
    tbl[1] = '{all_on: 1'b0, np: 3, pad: '{383,5,200,0,0,0,0,0,0}, cv: '{7,1,3,0,0,0,0,0,0},
               n: 3, ovf: 1'b0, eadr: '{5,200,383,0,0,0,0,0}, ecnt: '{1,3,7,0,0,0,0,0},
               pass: 3'd5, inj: -1};
    tbl[2] = '{all_on: 1'b1, np: 0, pad: '{0,0,0,0,0,0,0,0,0}, cv: '{0,0,0,0,0,0,0,0,0},
               n: 8, ovf: 1'b1, eadr: '{0,1,2,3,4,5,6,7}, ecnt: '{0,1,2,3,4,5,6,7},
               pass: 3'd2, inj: -1};
    tbl[3] = '{all_on: 1'b0, np: 8, pad: '{1,10,50,100,150,250,300,382,0},
               cv: '{1,2,2,4,6,2,4,6,0}, n: 8, ovf: 1'b0,
               eadr: '{1,10,50,100,150,250,300,382}, ecnt: '{1,2,2,4,6,2,4,6},
               pass: 3'd7, inj: 3};
    tbl[4] = '{all_on: 1'b0, np: 9, pad: '{1,10,50,100,150,250,300,382,383},
               cv: '{1,2,2,4,6,2,4,6,7}, n: 8, ovf: 1'b1,
               eadr: '{1,10,50,100,150,250,300,382}, ecnt: '{1,2,2,4,6,2,4,6},
               pass: 3'd3, inj: -1};
    tbl[5] = '{all_on: 1'b0, np: 2, pad: '{3,2,0,0,0,0,0,0,0}, cv: '{6,1,0,0,0,0,0,0,0},
               n: 2, ovf: 1'b0, eadr: '{2,3,0,0,0,0,0,0}, ecnt: '{1,6,0,0,0,0,0,0},
               pass: 3'd1, inj: -1};
    tbl[6] = '{all_on: 1'b0, np: 2, pad: '{383,0,0,0,0,0,0,0,0}, cv: '{4,5,0,0,0,0,0,0,0},
               n: 2, ovf: 1'b0, eadr: '{0,383,0,0,0,0,0,0}, ecnt: '{5,4,0,0,0,0,0,0},
               pass: 3'd6, inj: -1};

    // Reset and idle state.
    repeat (3) tick();
    check_idle("reset");
    reset = 1'b0;
    repeat (2) tick();
    check_idle("idle");

    for (int t = 0; t < 7; t++) run_frame(t);

    // Abort a 5-pad frame right after its second cluster.
    vpfs_i = '0;
    cnts_i = '0;
    vpfs_i[4] = 1'b1;   cnts_i[4*3 +: 3]   = 3'd4;
    vpfs_i[9] = 1'b1;   cnts_i[9*3 +: 3]   = 3'd1;
    vpfs_i[17] = 1'b1;  cnts_i[17*3 +: 3]  = 3'd1;
    vpfs_i[60] = 1'b1;  cnts_i[60*3 +: 3]  = 3'd4;
    vpfs_i[333] = 1'b1; cnts_i[333*3 +: 3] = 3'd5;
    pass_i  = 3'd4;
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    for (int e = 1; e <= (PIPE ? 4 : 2); e++) begin
      tick();
      j = emit_j(e, 5);
      check($sformatf("abort_e%0d_vpf", e), 64'(vpf_o), 64'(j >= 0));
      if (j == 0) check("abort_adr0", 64'(adr_o), 64'd4);
      if (j == 1) check("abort_adr1", 64'(adr_o), 64'd9);
    end
    #2 reset = 1'b1;
    #1 check_idle("abort");
    repeat (2) tick();
    reset = 1'b0;
    saw = 1'b0;
    for (int e = 0; e < 15; e++) begin
      tick();
      if (done_o || busy_o || vpf_o) saw = 1'b1;
    end
    check("abort_no_done", 64'(saw), 64'(0));
    run_frame(1);

    // 24-pad instance: pads 0 and 23, padded leaves 24..31 must never win.
    vpfs2 = 24'h800001;
    cnts2 = '0;
    cnts2[0 +: 3]  = 3'd2;
    cnts2[69 +: 3] = 3'd5;
    pass2  = 3'd3;
    start2 = 1'b1;
    tick();
    start2 = 1'b0;
    vpfs2  = '0;
    de = done_edge(2);
    for (int e = 1; e <= de; e++) begin
      tick();
      j = emit_j(e, 2);
      check($sformatf("k24_e%0d_vpf", e), 64'(vpf2), 64'(j >= 0));
      if (j >= 0) begin
        check($sformatf("k24_e%0d_adr", e), 64'(adr2), 64'((j == 0) ? 0 : 23));
        check($sformatf("k24_e%0d_cnt", e), 64'(cnt2), 64'((j == 0) ? 2 : 5));
      end
      if (vpf2) check($sformatf("k24_e%0d_range", e), 64'(adr2 < 5'd24), 64'(1));
      check($sformatf("k24_e%0d_done", e), 64'(done2), 64'(e == de));
    end
    check("k24_ncl", 64'(ncl2), 64'd2);
    check("k24_ovf", 64'(ovf2), 64'd0);
    check("k24_pass", 64'(passo2), 64'd3);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
